// File: rtl/adsr_envelope.sv
// adsr_envelope: per-voice ADSR envelope generator.
// Steps a 16-bit amplitude on each SAMPLE_EN strobe. KEY edges move the phase
// on any clock cycle, and an edge cycle never steps the level.
// Optional build macro ADSR_EXP_DECAY_EN: DEC and REL use an exponential
// decrement, max(1, ((ENV - target) * step) >> 16). The default build uses
// linear decrements and has no multiplier.
module adsr_envelope #(
    parameter logic [15:0] ENV_MAX = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        SAMPLE_EN,
    input  logic        KEY,
    input  logic [15:0] ATTACK,
    input  logic [15:0] DECAY,
    input  logic [15:0] SUSTAIN,
    input  logic [15:0] RLEASE,
    output logic [15:0] ENV,
    output logic [2:0]  STATE,
    output logic        ACTIVE
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ATK  = 3'd1,
        ST_DEC  = 3'd2,
        ST_SUS  = 3'd3,
        ST_REL  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] env_r;
    logic [15:0] env_nxt_s;
    logic        key_r;
    logic        active_r;
    logic        rise_s;
    logic        fall_s;
    logic [15:0] sus_lvl_s;
    logic [16:0] atk_sum_s;
    logic [16:0] dec_res_s;
    logic [16:0] rel_res_s;

    // One falling step toward target: returns {phase_done, new_level}.
    // The level never drops below target and never wraps.
    function automatic logic [16:0] fall_step(input logic [15:0] env,
                                              input logic [15:0] target,
                                              input logic [15:0] step);
        logic [16:0] result;
`ifdef ADSR_EXP_DECAY_EN
        logic [15:0] diff;
        logic [31:0] prod;
        logic [15:0] dec;
        diff = env - target;
        prod = diff * step;
        dec  = (prod[31:16] == 16'd0) ? 16'd1 : prod[31:16];
        if ((step == 16'd0) || (env <= target)) begin
            result = {1'b1, target};
        end else if (diff <= dec) begin
            result = {1'b1, target};
        end else begin
            result = {1'b0, env - dec};
        end
`else
        if ((step == 16'd0) ||
            ({1'b0, env} <= ({1'b0, target} + {1'b0, step}))) begin
            result = {1'b1, target};
        end else begin
            result = {1'b0, env - step};
        end
`endif
        return result;
    endfunction

    assign rise_s    = KEY & ~key_r;
    assign fall_s    = ~KEY & key_r;
    // Sustain is clamped so the level always stays inside [0, ENV_MAX].
    assign sus_lvl_s = (SUSTAIN > ENV_MAX) ? ENV_MAX : SUSTAIN;
    assign atk_sum_s = {1'b0, env_r} + {1'b0, ATTACK};
    assign dec_res_s = fall_step(env_r, sus_lvl_s, DECAY);
    assign rel_res_s = fall_step(env_r, 16'd0, RLEASE);

    // Next phase and level: KEY edges first, otherwise step on a sample tick.
    always_comb begin
        state_nxt_s = state_r;
        env_nxt_s   = env_r;
        if (rise_s) begin
            state_nxt_s = ST_ATK;
        end else if (fall_s) begin
            if ((state_r == ST_ATK) || (state_r == ST_DEC) || (state_r == ST_SUS)) begin
                state_nxt_s = ST_REL;
            end else begin
                state_nxt_s = state_r;
            end
        end else if (SAMPLE_EN) begin
            case (state_r)
                ST_IDLE: begin
                    env_nxt_s = 16'd0;
                end
                ST_ATK: begin
                    if ((ATTACK == 16'd0) || (atk_sum_s >= {1'b0, ENV_MAX})) begin
                        env_nxt_s   = ENV_MAX;
                        state_nxt_s = ST_DEC;
                    end else begin
                        env_nxt_s = atk_sum_s[15:0];
                    end
                end
                ST_DEC: begin
                    env_nxt_s = dec_res_s[15:0];
                    if (dec_res_s[16]) begin
                        state_nxt_s = ST_SUS;
                    end else begin
                        state_nxt_s = ST_DEC;
                    end
                end
                ST_SUS: begin
                    env_nxt_s = sus_lvl_s;
                end
                ST_REL: begin
                    env_nxt_s = rel_res_s[15:0];
                    if (rel_res_s[16]) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_REL;
                    end
                end
                default: begin
                    env_nxt_s   = 16'd0;
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, level, gate history and ACTIVE registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r  <= ST_IDLE;
            env_r    <= 16'd0;
            key_r    <= 1'b0;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            env_r    <= env_nxt_s;
            key_r    <= KEY;
            active_r <= (state_nxt_s != ST_IDLE);
        end
    end

    assign ENV    = env_r;
    assign STATE  = state_r;
    assign ACTIVE = active_r;

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed phase scenarios and a
// randomized run checked against a phase/level reference model.
module tb_adsr_envelope;

    logic        CLK;
    logic        RESET_N;
    logic        SAMPLE_EN;
    logic        KEY;
    logic [15:0] ATTACK;
    logic [15:0] DECAY;
    logic [15:0] SUSTAIN;
    logic [15:0] RLEASE;
    logic [15:0] ENV;
    logic [2:0]  STATE;
    logic        ACTIVE;

    int vectors;
    int errors;

    // Reference model: phase number 0..4 and integer level.
    int m_env;
    int m_phase;
    bit m_key;

    adsr_envelope dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .SAMPLE_EN(SAMPLE_EN),
        .KEY      (KEY),
        .ATTACK   (ATTACK),
        .DECAY    (DECAY),
        .SUSTAIN  (SUSTAIN),
        .RLEASE   (RLEASE),
        .ENV      (ENV),
        .STATE    (STATE),
        .ACTIVE   (ACTIVE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Move env toward target by one decrement; returns 1 when the phase ends.
    function automatic bit model_fall(input int env, input int target, input int step,
                                      output int nxt);
        int diff;
        int d;
        if (step == 0 || env <= target) begin
            nxt = target;
            return 1'b1;
        end
        diff = env - target;
`ifdef ADSR_EXP_DECAY_EN
        d = (diff * step) / 65536;
        if (d < 1) d = 1;
`else
        d = step;
`endif
        if (diff <= d) begin
            nxt = target;
            return 1'b1;
        end
        nxt = env - d;
        return 1'b0;
    endfunction

    task automatic model_update(input bit k, input bit s);
        bit rise;
        bit fall;
        int nxt;
        rise  = k && !m_key;
        fall  = !k && m_key;
        m_key = k;
        if (rise) begin
            m_phase = 1;
        end else if (fall) begin
            if (m_phase >= 1 && m_phase <= 3) m_phase = 4;
        end else if (s) begin
            case (m_phase)
                1: begin
                    if (ATTACK == 16'd0 || (m_env + int'(ATTACK)) >= 65535) begin
                        m_env   = 65535;
                        m_phase = 2;
                    end else begin
                        m_env = m_env + int'(ATTACK);
                    end
                end
                2: begin
                    if (model_fall(m_env, int'(SUSTAIN), int'(DECAY), nxt)) m_phase = 3;
                    m_env = nxt;
                end
                3: m_env = int'(SUSTAIN);
                4: begin
                    if (model_fall(m_env, 0, int'(RLEASE), nxt)) m_phase = 0;
                    m_env = nxt;
                end
                default: m_env = 0;
            endcase
        end
    endtask

    task automatic model_reset();
        m_env   = 0;
        m_phase = 0;
        m_key   = 1'b0;
    endtask

    // Called 1 time unit after a rising edge: drive inputs, advance the model,
    // and return 1 time unit after the next rising edge.
    task automatic drive_cycle(input bit k, input bit s);
        KEY       = k;
        SAMPLE_EN = s;
        model_update(k, s);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; KEY = 1'b0; SAMPLE_EN = 1'b0;
        ATTACK = 16'h0; DECAY = 16'h0; SUSTAIN = 16'h0; RLEASE = 16'h0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        vectors++; if (ENV !== 16'h0000) begin errors++; $display("FAIL reset_env got %h want 0000", ENV); end
        vectors++; if (STATE !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", STATE); end
        vectors++; if (ACTIVE !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", ACTIVE); end
        RESET_N = 1'b1;
        drive_cycle(1'b0, 1'b1);
        vectors++; if (ENV !== 16'h0000 || STATE !== 3'd0) begin errors++; $display("FAIL idle_tick got %h/%0d want 0000/0", ENV, STATE); end
    endtask

`ifndef ADSR_EXP_DECAY_EN
    task automatic test_attack();
        logic [15:0] exp_env [4];
        exp_env = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
        ATTACK = 16'h4000; DECAY = 16'h1000; SUSTAIN = 16'hC000; RLEASE = 16'h8000;
        drive_cycle(1'b1, 1'b0);
        vectors++; if (STATE !== 3'd1 || ACTIVE !== 1'b1 || ENV !== 16'h0000) begin
            errors++; $display("FAIL attack_edge got %0d/%b/%h want 1/1/0000", STATE, ACTIVE, ENV); end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 1'b1);
            vectors++; if (ENV !== exp_env[i]) begin errors++; $display("FAIL attack_step%0d got %h want %h", i, ENV, exp_env[i]); end
            drive_cycle(1'b1, 1'b0);
            vectors++; if (ENV !== exp_env[i]) begin errors++; $display("FAIL attack_hold%0d got %h want %h", i, ENV, exp_env[i]); end
        end
        vectors++; if (STATE !== 3'd2 || ACTIVE !== 1'b1) begin errors++; $display("FAIL attack_to_dec got %0d/%b want 2/1", STATE, ACTIVE); end
    endtask

    task automatic test_decay_sustain();
        logic [15:0] exp_env [4];
        exp_env = '{16'hEFFF, 16'hDFFF, 16'hCFFF, 16'hC000};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 1'b1);
            vectors++; if (ENV !== exp_env[i]) begin errors++; $display("FAIL decay_step%0d got %h want %h", i, ENV, exp_env[i]); end
        end
        vectors++; if (STATE !== 3'd3) begin errors++; $display("FAIL decay_to_sus got %0d want 3", STATE); end
        SUSTAIN = 16'h9000;
        drive_cycle(1'b1, 1'b0);
        vectors++; if (ENV !== 16'hC000) begin errors++; $display("FAIL sus_no_tick got %h want c000", ENV); end
        drive_cycle(1'b1, 1'b1);
        vectors++; if (ENV !== 16'h9000 || STATE !== 3'd3) begin errors++; $display("FAIL sus_follow got %h/%0d want 9000/3", ENV, STATE); end
        SUSTAIN = 16'hC000;
        drive_cycle(1'b1, 1'b1);
        vectors++; if (ENV !== 16'hC000) begin errors++; $display("FAIL sus_restore got %h want c000", ENV); end
    endtask

    task automatic test_release();
        RLEASE = 16'h8000;
        drive_cycle(1'b0, 1'b1);
        vectors++; if (STATE !== 3'd4 || ENV !== 16'hC000) begin errors++; $display("FAIL release_edge got %0d/%h want 4/c000", STATE, ENV); end
        drive_cycle(1'b0, 1'b1);
        vectors++; if (STATE !== 3'd4 || ENV !== 16'h4000) begin errors++; $display("FAIL release_step got %0d/%h want 4/4000", STATE, ENV); end
        drive_cycle(1'b0, 1'b1);
        vectors++; if (STATE !== 3'd0 || ENV !== 16'h0000 || ACTIVE !== 1'b0) begin
            errors++; $display("FAIL release_end got %0d/%h/%b want 0/0000/0", STATE, ENV, ACTIVE); end
    endtask

    task automatic test_retrigger();
        ATTACK = 16'h0000;
        drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b1, 1'b1);
        vectors++; if (ENV !== 16'hFFFF || STATE !== 3'd2) begin errors++; $display("FAIL attack_zero got %h/%0d want ffff/2", ENV, STATE); end
        DECAY = 16'h0000; SUSTAIN = 16'h8000;
        drive_cycle(1'b1, 1'b1);
        vectors++; if (ENV !== 16'h8000 || STATE !== 3'd3) begin errors++; $display("FAIL decay_zero got %h/%0d want 8000/3", ENV, STATE); end
        RLEASE = 16'h4000;
        drive_cycle(1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1);
        vectors++; if (ENV !== 16'h4000 || STATE !== 3'd4) begin errors++; $display("FAIL rel_setup got %h/%0d want 4000/4", ENV, STATE); end
        drive_cycle(1'b1, 1'b1);
        vectors++; if (ENV !== 16'h4000 || STATE !== 3'd1) begin errors++; $display("FAIL retrigger got %h/%0d want 4000/1", ENV, STATE); end
        drive_cycle(1'b1, 1'b1);
        vectors++; if (ENV !== 16'hFFFF || STATE !== 3'd2) begin errors++; $display("FAIL retrig_attack got %h/%0d want ffff/2", ENV, STATE); end
    endtask
`else
    task automatic test_exp_decay();
        logic [15:0] want;
        ATTACK = 16'h0000; DECAY = 16'h8000; SUSTAIN = 16'h0000; RLEASE = 16'h0000;
        drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b1, 1'b1);
        vectors++; if (ENV !== 16'hFFFF || STATE !== 3'd2) begin errors++; $display("FAIL exp_peak got %h/%0d want ffff/2", ENV, STATE); end
        for (int i = 0; i < 16; i++) begin
            want = 16'h8000 >> i;
            drive_cycle(1'b1, 1'b1);
            vectors++; if (ENV !== want || STATE !== 3'd2) begin errors++; $display("FAIL exp_step%0d got %h/%0d want %h/2", i, ENV, STATE, want); end
        end
        drive_cycle(1'b1, 1'b1);
        vectors++; if (ENV !== 16'h0000 || STATE !== 3'd3) begin errors++; $display("FAIL exp_end got %h/%0d want 0000/3", ENV, STATE); end
    endtask
`endif

    task automatic test_reset_mid_note();
        RLEASE = 16'h0000;
        drive_cycle(1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1);
        vectors++; if (STATE !== 3'd0) begin errors++; $display("FAIL rel_zero got %0d want 0", STATE); end
        ATTACK = 16'h4000;
        drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b1, 1'b1);
        drive_cycle(1'b1, 1'b1);
        vectors++; if (ENV !== 16'h8000 || STATE !== 3'd1) begin errors++; $display("FAIL pre_reset got %h/%0d want 8000/1", ENV, STATE); end
        #3;
        RESET_N = 1'b0;
        #1;
        vectors++; if (ENV !== 16'h0000 || STATE !== 3'd0 || ACTIVE !== 1'b0) begin
            errors++; $display("FAIL async_reset got %h/%0d/%b want 0000/0/0", ENV, STATE, ACTIVE); end
        KEY = 1'b0;
        model_reset();
        #2;
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1);
            vectors++; if (ENV !== 16'h0000 || STATE !== 3'd0) begin errors++; $display("FAIL post_reset%0d got %h/%0d want 0000/0", i, ENV, STATE); end
        end
    endtask

    task automatic test_random();
        bit k;
        bit s;
        k = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 24) == 0) k = ~k;
            s = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 30) == 0) ATTACK  = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h3000));
            if ($urandom_range(0, 30) == 0) DECAY   = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h3000));
            if ($urandom_range(0, 30) == 0) SUSTAIN = 16'($urandom_range(0, 16'hFFFF));
            if ($urandom_range(0, 30) == 0) RLEASE  = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h3000));
            drive_cycle(k, s);
            vectors++;
            if (ENV !== 16'(m_env) || STATE !== 3'(m_phase) || ACTIVE !== (m_phase != 0)) begin
                errors++;
                $display("FAIL random%0d got env=%h state=%0d active=%b want env=%h state=%0d active=%b",
                         n, ENV, STATE, ACTIVE, 16'(m_env), m_phase, (m_phase != 0));
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
`ifndef ADSR_EXP_DECAY_EN
        test_attack();
        test_decay_sustain();
        test_release();
        test_retrigger();
`else
        test_exp_decay();
`endif
        test_reset_mid_note();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
